// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle control unit: ALU codes, opcodes,
// operand/result select encodings and the controller state type.
package multicycle_ctrl_pkg;

    // ALUControl codes
    localparam logic [2:0] AluIdle = 3'b000;
    localparam logic [2:0] AluAdd  = 3'b001;
    localparam logic [2:0] AluSub  = 3'b010;
    localparam logic [2:0] AluOr   = 3'b011;
    localparam logic [2:0] AluAnd  = 3'b100;
    localparam logic [2:0] AluEq   = 3'b101;
    localparam logic [2:0] AluNeq  = 3'b110;

    // Supported RV32 opcodes
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpRtype  = 7'b0110011;
    localparam logic [6:0] OpItype  = 7'b0010011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;

    // ALU operand A select
    localparam logic [1:0] SrcAPc    = 2'b00;
    localparam logic [1:0] SrcAOldPc = 2'b01;
    localparam logic [1:0] SrcARegA  = 2'b10;

    // ALU operand B select
    localparam logic [1:0] SrcBRegB = 2'b00;
    localparam logic [1:0] SrcBImm  = 2'b01;
    localparam logic [1:0] SrcBFour = 2'b10;

    // Result mux select
    localparam logic [1:0] ResAluOut    = 2'b00;
    localparam logic [1:0] ResMemData   = 2'b01;
    localparam logic [1:0] ResAluResult = 2'b10;

    typedef enum logic [3:0] {
        StFetch,
        StDecode,
        StMemAdr,
        StMemRead,
        StMemWb,
        StMemWrite,
        StExecR,
        StExecI,
        StAluWb,
        StBranch,
        StJal
    } ctrl_state_e;

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU decoder: maps opcode/funct fields to an ALUControl code
// and flags funct encodings the controller does not support.
module alu_decoder
    import multicycle_ctrl_pkg::*;
(
    input  logic [6:0] op_i,
    input  logic [2:0] funct3_i,
    input  logic       funct7b5_i,
    output logic [2:0] alu_ctrl_o,
    output logic       illegal_o
);

    // Decode funct fields; opcodes without an ALU function default to add.
    always_comb begin
        alu_ctrl_o = AluAdd;
        illegal_o  = 1'b0;
        case (op_i)
            OpRtype, OpItype: begin
                case (funct3_i)
                    3'b000:  alu_ctrl_o = (op_i == OpRtype && funct7b5_i) ? AluSub : AluAdd;
                    3'b110:  alu_ctrl_o = AluOr;
                    3'b111:  alu_ctrl_o = AluAnd;
                    default: illegal_o  = 1'b1;
                endcase
                // Only R-type add/sub uses bit 30
                if (op_i == OpRtype && funct7b5_i && funct3_i != 3'b000) begin
                    illegal_o = 1'b1;
                end
            end
            OpBranch: begin
                case (funct3_i)
                    3'b000:  alu_ctrl_o = AluEq;
                    3'b001:  alu_ctrl_o = AluNeq;
                    default: illegal_o  = 1'b1;
                endcase
            end
            default: begin
                alu_ctrl_o = AluAdd;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Main control FSM of the multicycle processor. Sequences the shared ALU
// through fetch/decode/execute/memory/writeback, stalls on MemReady and
// counts retired instructions.
module multicycle_ctrl_fsm #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       Op,
    input  logic [2:0]       Funct3,
    input  logic             Funct7b5,
    input  logic             ALUFlag,
    input  logic             MemReady,
    output logic [2:0]       ALUControl,
    output logic [1:0]       ALUSrcASel,
    output logic [1:0]       ALUSrcBSel,
    output logic [1:0]       ResultSrc,
    output logic             AdrSrc,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             MemWrite,
    output logic             RegWrite,
    output logic             IllegalInstr,
    output logic [CNT_W-1:0] RetiredCnt
);
    import multicycle_ctrl_pkg::*;

    ctrl_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [2:0] dec_alu;
    logic       dec_illegal;
    logic       op_known;
    logic       instr_illegal;

    logic [2:0] alu_ctrl;
    logic       ir_write, pc_update, mem_write, reg_write, illegal, retire;

    alu_decoder u_alu_decoder (
        .op_i       (Op),
        .funct3_i   (Funct3),
        .funct7b5_i (Funct7b5),
        .alu_ctrl_o (dec_alu),
        .illegal_o  (dec_illegal)
    );

    assign op_known = (Op == OpLoad) || (Op == OpStore) || (Op == OpRtype) ||
                      (Op == OpItype) || (Op == OpBranch) || (Op == OpJal);
    assign instr_illegal = !op_known || dec_illegal;

    // State register and retired-instruction counter, synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StFetch;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and Moore output decode.
    always_comb begin
        state_d    = state_q;
        alu_ctrl   = AluIdle;
        ALUSrcASel = SrcAPc;
        ALUSrcBSel = SrcBRegB;
        ResultSrc  = ResAluOut;
        AdrSrc     = 1'b0;
        ir_write   = 1'b0;
        pc_update  = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        illegal    = 1'b0;
        retire     = 1'b0;
        unique case (state_q)
            StFetch: begin
                ALUSrcBSel = SrcBFour;
                alu_ctrl   = AluAdd;
                ResultSrc  = ResAluResult;
                if (MemReady) begin
                    ir_write  = 1'b1;
                    pc_update = 1'b1;
                    state_d   = StDecode;
                end
            end
            StDecode: begin
                // Branch/jal target lands in ALUOut
                ALUSrcASel = SrcAOldPc;
                ALUSrcBSel = SrcBImm;
                alu_ctrl   = AluAdd;
                if (instr_illegal) begin
                    illegal = 1'b1;
                    state_d = StFetch;
                end else begin
                    case (Op)
                        OpLoad, OpStore: state_d = StMemAdr;
                        OpRtype:         state_d = StExecR;
                        OpItype:         state_d = StExecI;
                        OpBranch:        state_d = StBranch;
                        OpJal:           state_d = StJal;
                        default:         state_d = StFetch;
                    endcase
                end
            end
            StMemAdr: begin
                ALUSrcASel = SrcARegA;
                ALUSrcBSel = SrcBImm;
                alu_ctrl   = AluAdd;
                state_d    = (Op == OpLoad) ? StMemRead : StMemWrite;
            end
            StMemRead: begin
                AdrSrc = 1'b1;
                if (MemReady) begin
                    state_d = StMemWb;
                end
            end
            StMemWb: begin
                ResultSrc = ResMemData;
                reg_write = 1'b1;
                retire    = 1'b1;
                state_d   = StFetch;
            end
            StMemWrite: begin
                AdrSrc    = 1'b1;
                mem_write = 1'b1;
                if (MemReady) begin
                    retire  = 1'b1;
                    state_d = StFetch;
                end
            end
            StExecR: begin
                ALUSrcASel = SrcARegA;
                ALUSrcBSel = SrcBRegB;
                alu_ctrl   = dec_alu;
                state_d    = StAluWb;
            end
            StExecI: begin
                ALUSrcASel = SrcARegA;
                ALUSrcBSel = SrcBImm;
                alu_ctrl   = dec_alu;
                state_d    = StAluWb;
            end
            StAluWb: begin
                ResultSrc = ResAluOut;
                reg_write = 1'b1;
                retire    = 1'b1;
                state_d   = StFetch;
            end
            StBranch: begin
                ALUSrcASel = SrcARegA;
                ALUSrcBSel = SrcBRegB;
                alu_ctrl   = dec_alu;
                ResultSrc  = ResAluOut;
                retire     = 1'b1;
                state_d    = StFetch;
            end
            StJal: begin
                // PC <- target held in ALUOut; ALU forms OldPC+4 for rd
                ALUSrcASel = SrcAOldPc;
                ALUSrcBSel = SrcBFour;
                alu_ctrl   = AluAdd;
                ResultSrc  = ResAluOut;
                pc_update  = 1'b1;
                state_d    = StAluWb;
            end
            default: begin
                state_d = StFetch;
            end
        endcase
    end

    // Counter next value; wraps silently.
    always_comb begin
        cnt_d = cnt_q;
        if (retire) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Enables and ALU code are forced idle while reset is held.
    always_comb begin
        ALUControl   = reset ? AluIdle : alu_ctrl;
        IRWrite      = !reset && ir_write;
        PCWrite      = !reset && (pc_update || (state_q == StBranch && ALUFlag));
        MemWrite     = !reset && mem_write;
        RegWrite     = !reset && reg_write;
        IllegalInstr = !reset && illegal;
        RetiredCnt   = cnt_q;
    end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Bench for multicycle_ctrl_fsm: directed reset/illegal/abort checks plus a
// randomized instruction stream scored per instruction window.
module tb_multicycle_ctrl_fsm;

    localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
    localparam logic [6:0] IT = 7'b0010011, BR = 7'b1100011, JL = 7'b1101111;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] Op = '0;
    logic [2:0] Funct3 = '0;
    logic       Funct7b5 = 1'b0;
    logic       ALUFlag = 1'b0;
    logic       MemReady = 1'b1;
    logic [2:0] ALUControl;
    logic [1:0] ALUSrcASel, ALUSrcBSel, ResultSrc;
    logic       AdrSrc, IRWrite, PCWrite, MemWrite, RegWrite, IllegalInstr;
    logic [3:0] RetiredCnt;

    multicycle_ctrl_fsm #(.CNT_W(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .Op           (Op),
        .Funct3       (Funct3),
        .Funct7b5     (Funct7b5),
        .ALUFlag      (ALUFlag),
        .MemReady     (MemReady),
        .ALUControl   (ALUControl),
        .ALUSrcASel   (ALUSrcASel),
        .ALUSrcBSel   (ALUSrcBSel),
        .ResultSrc    (ResultSrc),
        .AdrSrc       (AdrSrc),
        .IRWrite      (IRWrite),
        .PCWrite      (PCWrite),
        .MemWrite     (MemWrite),
        .RegWrite     (RegWrite),
        .IllegalInstr (IllegalInstr),
        .RetiredCnt   (RetiredCnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         regw, memw, pcw, ill, adr;
        bit         chk3;
        logic [2:0] alu3;
        logic [1:0] asel3, bsel3, rsrc;
        logic [3:0] ret;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0, n_fail = 0;
    bit   mon_en = 0;
    logic [3:0] model_cnt = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    // Inputs change just after the rising edge and hold for one cycle.
    task automatic step(input logic mr, input logic af);
        MemReady = mr;
        ALUFlag  = af;
        @(posedge clk);
        #1;
    endtask

    // Reference model: one instruction -> expected strobe counts per window.
    task automatic run_instr();
        int kind, f, w, lat, sel;
        logic [6:0] op;
        logic [2:0] f3;
        logic f7, af3;
        exp_t e;
        kind = $urandom_range(0, 7);
        f    = $urandom_range(0, 2);
        w    = (kind <= 1) ? $urandom_range(0, 3) : 0;
        af3  = rb();
        f7   = rb();
        f3   = 3'($urandom_range(0, 7));
        sel  = $urandom_range(0, 2);
        e.alu3 = 3'b001; e.asel3 = 2'b10; e.bsel3 = 2'b01;
        case (kind)
            0: begin op = LW; f3 = 3'b010; lat = 5; end
            1: begin op = SW; f3 = 3'b010; lat = 4; end
            2, 3: begin
                op  = (kind == 2) ? RT : IT;
                lat = 4;
                f3  = (sel == 0) ? 3'b000 : (sel == 1) ? 3'b110 : 3'b111;
                if (kind == 2 && f3 != 3'b000) f7 = 1'b0;
                if (f3 == 3'b110) e.alu3 = 3'b011;
                else if (f3 == 3'b111) e.alu3 = 3'b100;
                else e.alu3 = (kind == 2 && f7) ? 3'b010 : 3'b001;
                if (kind == 2) e.bsel3 = 2'b00;
            end
            4: begin
                op = BR; lat = 3; f3 = {2'b00, f7};
                e.alu3 = f7 ? 3'b110 : 3'b101; e.bsel3 = 2'b00;
            end
            5: begin op = JL; lat = 4; e.asel3 = 2'b01; e.bsel3 = 2'b10; end
            6: begin
                lat = 2;
                do op = 7'($urandom_range(0, 127));
                while (op == LW || op == SW || op == RT || op == IT || op == BR || op == JL);
            end
            default: begin
                lat = 2;
                op  = rb() ? RT : IT;
                if (op == RT && rb()) begin
                    f3 = rb() ? 3'b110 : 3'b111; f7 = 1'b1;
                end else begin
                    f3 = 3'($urandom_range(1, 5));
                end
            end
        endcase
        e.regw = (kind == 0 || kind == 2 || kind == 3 || kind == 5) ? 1 : 0;
        e.memw = (kind == 1) ? w + 1 : 0;
        e.adr  = (kind <= 1) ? w + 1 : 0;
        e.pcw  = 1 + ((kind == 4 && af3) ? 1 : 0) + ((kind == 5) ? 1 : 0);
        e.ill  = (kind >= 6) ? 1 : 0;
        e.chk3 = (kind < 6);
        e.rsrc = (kind == 0) ? 2'b01 : 2'b00;
        if (kind < 6) model_cnt = model_cnt + 4'd1;
        e.ret  = model_cnt;
        sb.push_back(e);

        Op = op; Funct3 = f3; Funct7b5 = f7;
        repeat (f) step(1'b0, rb());
        step(1'b1, rb());
        for (int j = 2; j <= lat; j++) begin
            if (j == 4 && kind <= 1) begin
                repeat (w) step(1'b0, rb());
                step(1'b1, rb());
            end else if (j == 3) begin
                step(rb(), af3);
            end else begin
                step(rb(), rb());
            end
        end
    endtask

    // Monitor: a window runs from one IRWrite to the next; closing it scores
    // the instruction fetched at the window start.
    bit         m_open = 0, m_got3 = 0;
    int         m_idx, m_rw, m_mw, m_pw, m_il, m_ad;
    logic [2:0] m_alu3;
    logic [1:0] m_as3, m_bs3, m_rs;
    exp_t       m_e;

    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (IRWrite) begin
                    if (m_open) begin
                        if (sb.size() == 0) begin
                            n_chk++; n_fail++;
                            $display("FAIL sb_underflow: got window, expected none");
                        end else begin
                            m_e = sb.pop_front();
                            check("regwrite_cnt", m_rw, m_e.regw);
                            check("memwrite_cnt", m_mw, m_e.memw);
                            check("pcwrite_cnt", m_pw, m_e.pcw);
                            check("illegal_cnt", m_il, m_e.ill);
                            check("adrsrc_cnt", m_ad, m_e.adr);
                            check("retired_cnt", RetiredCnt, m_e.ret);
                            if (m_e.regw > 0) check("resultsrc_wb", m_rs, m_e.rsrc);
                            if (m_e.chk3) begin
                                check("cycle3_seen", m_got3, 1);
                                check("cycle3_alu", m_alu3, m_e.alu3);
                                check("cycle3_asel", m_as3, m_e.asel3);
                                check("cycle3_bsel", m_bs3, m_e.bsel3);
                            end
                        end
                    end
                    m_open = 1; m_idx = 1; m_got3 = 0;
                    m_rw = 0; m_mw = 0; m_pw = 0; m_il = 0; m_ad = 0; m_rs = 2'bxx;
                end else if (m_open) begin
                    m_idx++;
                end
                if (m_open) begin
                    m_rw += int'(RegWrite);
                    m_mw += int'(MemWrite);
                    m_pw += int'(PCWrite);
                    m_il += int'(IllegalInstr);
                    m_ad += int'(AdrSrc);
                    if (RegWrite) m_rs = ResultSrc;
                    if (m_idx == 3) begin
                        m_got3 = 1; m_alu3 = ALUControl; m_as3 = ALUSrcASel; m_bs3 = ALUSrcBSel;
                    end
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Two reset cycles with MemReady high: enables must stay low.
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_irwrite", IRWrite, 0);
        check("rst_pcwrite", PCWrite, 0);
        check("rst_alu", ALUControl, 0);
        check("rst_regwrite", RegWrite, 0);
        check("rst_memwrite", MemWrite, 0);
        check("rst_illegal", IllegalInstr, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        Op = 7'b1111111;
        @(negedge clk);
        check("fetch_cnt", RetiredCnt, 0);
        check("fetch_irwrite", IRWrite, 1);
        check("fetch_pcwrite", PCWrite, 1);
        check("fetch_alu", ALUControl, 3'b001);
        check("fetch_bsel", ALUSrcBSel, 2'b10);
        check("fetch_asel", ALUSrcASel, 2'b00);
        check("fetch_resultsrc", ResultSrc, 2'b10);
        check("fetch_adrsrc", AdrSrc, 0);

        // Unsupported opcode: one-cycle pulse in DECODE, then FETCH, not counted.
        @(posedge clk); #1;
        @(negedge clk);
        check("ill_pulse", IllegalInstr, 1);
        check("ill_regwrite", RegWrite, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("ill_pulse_end", IllegalInstr, 0);
        check("ill_back_fetch", IRWrite, 1);
        check("ill_cnt", RetiredCnt, 0);

        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        model_cnt = '0;

        // Random stream; 4-bit counter wraps many times.
        mon_en = 1;
        for (int i = 0; i < 250; i++) run_instr();

        // A store fetch closes the last window, then reset aborts it in MEMWRITE.
        Op = SW; Funct3 = 3'b010; Funct7b5 = 1'b0;
        step(1'b1, 1'b0);
        mon_en = 0;
        check("sb_drained", sb.size(), 0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        MemReady = 1'b0;
        @(negedge clk);
        check("sw_memwrite", MemWrite, 1);
        check("sw_adrsrc", AdrSrc, 1);
        check("sw_cnt_before", RetiredCnt, model_cnt);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check("abort_memwrite", MemWrite, 0);
        check("abort_alu", ALUControl, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        MemReady = 1'b1;
        @(negedge clk);
        check("abort_cnt", RetiredCnt, 0);
        check("abort_fetch", IRWrite, 1);
        check("abort_no_regwrite", RegWrite, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl_fsm.md
Name: multicycle_ctrl_fsm

Overview:
Main control unit of the multicycle processor. It sequences the shared ALU_TOP through fetch, decode, execute, memory and writeback steps. Each state drives ALUControl and the ALUSrcA/ALUSrcB operand selects, plus all datapath write enables. It supports an RV32 subset (lw, sw, R add/sub/or/and, I addi/ori/andi, beq/bne, jal), stalls on a memory-ready handshake, and counts retired instructions.

Parameters:
CNT_W, 32, width of retired-instruction counter RetiredCnt

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
Op  in  7  instruction opcode (Instr[6:0]), valid from DECODE onward
Funct3  in  3  Instr[14:12]
Funct7b5  in  1  Instr[30]
ALUFlag  in  1  ALUResult[0] from ALU_TOP (eq/neq result)
MemReady  in  1  memory completes current access this cycle
ALUControl  out  3  001 add, 010 sub, 011 or, 100 and, 101 eq, 110 neq, 000 idle
ALUSrcASel  out  2  00 PC, 01 OldPC, 10 RegA
ALUSrcBSel  out  2  00 RegB, 01 Imm, 10 const 4
ResultSrc  out  2  00 ALUOut, 01 MemData, 10 ALUResult
AdrSrc  out  1  0 PC, 1 ALUOut
IRWrite  out  1  latch instruction and OldPC
PCWrite  out  1  PC load enable
MemWrite  out  1  memory write strobe
RegWrite  out  1  register-file write
IllegalInstr  out  1  one-cycle pulse on unsupported instruction
RetiredCnt  out  CNT_W  retired-instruction count

Behaviour:
- Reset: synchronous; the state register loads FETCH and RetiredCnt loads 0 on the rising clk edge with reset=1. While reset=1, all enables (IRWrite, PCWrite, MemWrite, RegWrite, IllegalInstr) are forced 0 and ALUControl=000. Reset mid-instruction aborts it with no write.
- Outputs are Moore-decoded from state, except PCWrite = PCUpdate | (BRANCH & ALUFlag) and the MemReady gating listed below.
- States, outputs and transitions (unlisted outputs are 0 or 00):
- FETCH: AdrSrc=0, ASel=00, BSel=10, add, ResultSrc=10. IRWrite and PCUpdate are asserted only when MemReady=1. Stays in FETCH while MemReady=0; goes to DECODE when MemReady=1.
- DECODE: ASel=01, BSel=01, add (branch/jal target into ALUOut). Next state by Op: 0000011/0100011 go to MEMADR; 0110011 to EXECR; 0010011 to EXECI; 1100011 to BRANCH; 1101111 to JAL. Any other Op, or an illegal Funct3/Funct7b5, pulses IllegalInstr for one cycle and goes to FETCH.
- MEMADR: ASel=10, BSel=01, add. Goes to MEMREAD for lw, MEMWRITE for sw.
- MEMREAD: AdrSrc=1. Waits for MemReady=1, then goes to MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, then goes to FETCH.
- MEMWRITE: AdrSrc=1, MemWrite=1 held until MemReady=1, then goes to FETCH.
- EXECR: ASel=10, BSel=00, ALUControl from decoder, then goes to ALUWB.
- EXECI: ASel=10, BSel=01, ALUControl from decoder (never sub), then goes to ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, then goes to FETCH.
- BRANCH: ASel=10, BSel=00, ALUControl=101 for Funct3=000 and 110 for Funct3=001, ResultSrc=00. PCWrite=ALUFlag. Goes to FETCH.
- JAL: ASel=01, BSel=10, add, ResultSrc=00 (PC <- target), PCUpdate=1, then goes to ALUWB (rd <- OldPC+4).
- ALU decode:
  - Funct3 000: add, or sub when Op=0110011 and Funct7b5=1.
  - Funct3 110: or. Funct3 111: and. All other Funct3 values are illegal.
  - Funct7b5=1 with Funct3≠000 under R-type is illegal.
- RetiredCnt increments by 1 on each transition into FETCH from MEMWB, MEMWRITE, ALUWB or BRANCH. Illegal instructions are not counted. The counter wraps modulo 2^CNT_W with no flag.
- Instruction latency with MemReady tied to 1: lw 5, sw 4, R/I 4, branch 3, jal 4 cycles.

Decomposition:
- Package multicycle_ctrl_pkg holds:
  - the ALUControl code constants;
  - opcode constants;
  - the ASel/BSel/ResultSrc encodings;
  - the state enum typedef.
- Sub-module alu_decoder: combinational; maps Op, Funct3, Funct7b5 to ALUControl and an illegal flag.

Test Plan:
- reset=1 for 2 cycles, then add (Op 0110011, F3 000, F7b5 0), MemReady=1 -> states FETCH,DECODE,EXECR,ALUWB. EXECR shows ALUControl=001, ASel=10, BSel=00. ALUWB shows RegWrite=1. RetiredCnt=1.
- sub (F7b5=1) -> ALUControl=010 in EXECR. andi (Op 0010011, F3 111) -> ALUControl=100, BSel=01.
- lw with MemReady low for 3 cycles in MEMREAD -> stays in MEMREAD 4 cycles, AdrSrc=1, no RegWrite. MEMWB then has RegWrite=1, ResultSrc=01.
- beq with ALUFlag=1 -> PCWrite=1, ALUControl=101. bne with ALUFlag=0 -> ALUControl=110, PCWrite=0. Both end in FETCH and increment RetiredCnt.
- Op 1111111 -> IllegalInstr high exactly one cycle in DECODE, then FETCH, RetiredCnt unchanged. reset asserted during MEMWRITE -> MemWrite=0 in that cycle, state FETCH, count 0.
- CNT_W=4 with 16 retired instructions -> RetiredCnt wraps 15 to 0.
